// File: rtl/ts_bank_manager.sv
// Per-frame timestamp bank manager: NUM_GROUPS ping-pong (timestamp, active-pixel)
// bank pairs with line-synchronous swap and group sequencing.
module ts_bank_manager #(
   parameter int unsigned NUM_GROUPS = 5,
   parameter int unsigned ADDR_W     = 9,
   parameter int unsigned TS_W       = 16,
   parameter int unsigned LINE_W     = 8,
   parameter int unsigned CYC_W      = 8
) (
   input  logic              clk_i,
   input  logic              nrst_i,
   input  logic              new_line_i,
   input  logic              mem_updated_i,
   input  logic              err_clr_i,
   input  logic [CYC_W-1:0]  mem_cycles_i,
   input  logic [LINE_W-1:0] lines_per_frame_i,
   input  logic [2:0]        last_group_i,
   input  logic              wen_i,
   input  logic [2:0]        wgrp_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [TS_W:0]     wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic              bank_sel_o,
   output logic [2:0]        rd_grp_o,
   output logic [TS_W-1:0]   timestamp_o,
   output logic              active_pixel_o,
   output logic              frame_start_o,
   output logic              swap_pending_o,
   output logic              swap_err_o
);

   localparam int unsigned DEPTH   = 2**ADDR_W;
   localparam int unsigned NBANKS  = 2 * NUM_GROUPS;
   localparam int unsigned BIDX_W  = $clog2(NBANKS);
   localparam logic [2:0]  MAX_GRP = 3'(NUM_GROUPS - 1);

   typedef enum logic {
      ST_RUN,
      ST_WAIT
   } state_t;

   state_t              state_q, state_d;
   logic [CYC_W-1:0]    cyc_q, cyc_d;
   logic [LINE_W-1:0]   line_q;
   logic                upd_q;
   logic                avail;
   logic                swap;
   logic                line_end;
   logic [2:0]          last_grp_eff;
   logic                wr_ok;
   logic [BIDX_W-1:0]   w_idx, r_idx;

   // Bank index packs {group, bank}; groups never exceed NUM_GROUPS-1 when used.
   logic [TS_W:0]       mem [NBANKS][DEPTH];

   assign w_idx        = BIDX_W'({wgrp_i, ~bank_sel_o});
   assign r_idx        = BIDX_W'({rd_grp_o, bank_sel_o});
   assign wr_ok        = wen_i && ({1'b0, wgrp_i} < 4'(NUM_GROUPS));
   assign last_grp_eff = (last_group_i > MAX_GRP) ? MAX_GRP : last_group_i;
   assign line_end     = new_line_i && (line_q == lines_per_frame_i);
   assign avail        = upd_q | mem_updated_i;
   assign swap_pending_o = (state_q == ST_WAIT);

   always_ff @(posedge clk_i) begin
      if (wr_ok) mem[w_idx][waddr_i] <= wdata_i;
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      swap    = 1'b0;
      if (new_line_i) begin
         unique case (state_q)
            ST_RUN: begin
               if (cyc_q < mem_cycles_i) cyc_d = cyc_q + 1'b1;
               else if (avail)           swap  = 1'b1;
               else                      state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (avail) begin
                  swap    = 1'b1;
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
      if (swap) cyc_d = '0;
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q        <= ST_RUN;
         cyc_q          <= '0;
         line_q         <= '0;
         upd_q          <= 1'b0;
         bank_sel_o     <= 1'b0;
         rd_grp_o       <= '0;
         frame_start_o  <= 1'b0;
         swap_err_o     <= 1'b0;
         timestamp_o    <= '0;
         active_pixel_o <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         if (swap) bank_sel_o <= ~bank_sel_o;

         if (swap)               upd_q <= 1'b0;
         else if (mem_updated_i) upd_q <= 1'b1;

         // A fresh update landing on an unconsumed one is an overrun; set beats clear.
         if (mem_updated_i && upd_q && !swap) swap_err_o <= 1'b1;
         else if (err_clr_i)                  swap_err_o <= 1'b0;

         frame_start_o <= line_end;
         if (new_line_i) begin
            if (line_end) begin
               line_q   <= '0;
               rd_grp_o <= (rd_grp_o >= last_grp_eff) ? 3'd0 : rd_grp_o + 3'd1;
            end else begin
               line_q <= line_q + 1'b1;
            end
         end

         {active_pixel_o, timestamp_o} <= mem[r_idx][raddr_i];
      end
   end

endmodule
